timing_check_monitor: RTL
=========================

# timing_check_monitor

Synthesisable, cycle-based counterpart of specify-block timing checks: monitors a reference strobe and a bank of data channels and flags setup, hold and minimum-pulse-width violations measured in `clk` cycles. Generalises the single-signal `$setup`/`$hold`/`$width` checks to N channels with programmable windows, a notifier output and violation logging. It sits beside the simulator's timing-check regression as a hardware-checkable golden model and as a standalone protocol monitor.

## Interface
- `CHANNELS`, 8: number of monitored data bits (1..32).
- `SETUP_CYC`, 3: required stable cycles before the reference edge; 0 disables setup checks.
- `HOLD_CYC`, 2: cycles after the reference edge during which data must not change; 0 disables hold checks.
- `WIDTH_MIN`, 4: minimum high-phase length of `ref_in` in cycles; 0 disables the width check.
- `CNT_W`, 16: width of the violation counter.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: check enable; low suppresses all flags.
- `ref_in` in 1: reference signal; its rising edge is the check event.
- `data` in CHANNELS: monitored data.
- `setup_viol` out CHANNELS: one-cycle pulse per violating channel.
- `hold_viol` out CHANNELS: one-cycle pulse per violating channel.
- `width_viol` out 1: one-cycle pulse.
- `notifier` out 1: toggles once per cycle in which any violation flag is asserted.
- `viol_count` out CNT_W: saturating count of violation cycles.
- `last_kind` out 2: kind of the most recent violation (NONE/SETUP/HOLD/WIDTH; SETUP wins over HOLD over WIDTH if simultaneous).

## Operation
- Internal regs: `ref_q` (previous `ref_in`), `d_q` (previous `data`). Rising edge at cycle t: `ref_in & ~ref_q`; falling: `~ref_in & ref_q`. Change on channel i at t: `data[i] != d_q[i]`.
- Stable age a_i: per-channel counter, cleared to 0 on change, else incremented, saturating at SETUP_CYC.
- Setup: at rising edge, channel i violates if a_i (after this cycle's update) < SETUP_CYC. A change in the edge cycle itself is a setup violation.
- Hold: rising edge opens a window covering cycles t+1..t+HOLD_CYC. First change on channel i inside the window flags hold_viol[i]; further changes in the same window are not flagged again. A new rising edge inside an open window restarts it (old window closes unflagged).
- Width: high counter h counts cycles with `ref_in`=1 (saturating at WIDTH_MIN), cleared on rising edge. At falling edge, h < WIDTH_MIN flags width_viol.
- `en`=0: no flags, hold windows close; age and width counters keep tracking so checks resume correctly.
- `viol_count` increments by 1 per cycle with any flag, saturates at all-ones.

## Timing
- All outputs registered; detection at cycle t -> flag high in cycle t+1 for exactly one cycle; notifier and viol_count update in t+1.
- Reset values: all viol outputs 0, notifier 0, viol_count 0, last_kind NONE, ref_q 0, d_q 0, ages saturated at SETUP_CYC, h 0, windows closed.
- `ref_in` high on first post-reset cycle counts as a rising edge. Reset mid-window discards the window; reset during a high phase never flags width.
- Setup and hold flags may fire in the same cycle on the same channel (new edge plus change closing the previous window).

## Structure
- Package `timing_chk_pkg`: `viol_kind_t` enum (NONE=0, SETUP=1, HOLD=2, WIDTH=3) and priority-encode helper.
- Sub-module `tc_channel`: one channel's age counter, setup compare and hold window; instantiated CHANNELS times via generate. Width logic, notifier, counter and last_kind in the top.

## Test plan
- CHANNELS=4, SETUP_CYC=3: change data[2] at t, rising edge at t+2 -> setup_viol=4'b0100 at t+3, notifier toggles, viol_count=1, last_kind=SETUP.
- Data stable 5 cycles, edge at t, data[0] changes at t+2 (HOLD_CYC=2) -> hold_viol=4'b0001 at t+3; change at t+3 instead -> no flag.
- WIDTH_MIN=4: ref_in high 3 cycles -> width_viol one cycle after falling edge; high 4 cycles -> none.
- en=0 across an edge with a setup violation -> no flags, count unchanged; en=1 at next compliant edge -> no flags.
- 70000 forced violations with CNT_W=16 -> viol_count holds 16'hFFFF.
- Assert rst inside open hold window, then change data -> no hold_viol; all outputs at reset values the cycle after rst.

Source files
------------

// File: rtl/timing_chk_pkg.sv
// Shared types for the timing-check monitor: violation kinds and the
// priority rule used to report the most recent kind.
package timing_chk_pkg;

    typedef enum logic [1:0] {
        VK_NONE  = 2'd0,
        VK_SETUP = 2'd1,
        VK_HOLD  = 2'd2,
        VK_WIDTH = 2'd3
    } viol_kind_t;

    function automatic viol_kind_t prio_kind(input logic i_setup,
                                             input logic i_hold,
                                             input logic i_width);
        viol_kind_t k;
        if (i_setup) begin
            k = VK_SETUP;
        end else if (i_hold) begin
            k = VK_HOLD;
        end else if (i_width) begin
            k = VK_WIDTH;
        end else begin
            k = VK_NONE;
        end
        return k;
    endfunction

endpackage

// File: rtl/tc_channel.sv
// One monitored data bit: stable-age counter for the setup check and a
// countdown window that catches the first change after a reference edge.
module tc_channel #(
    parameter int SETUP_CYC = 3,
    parameter int HOLD_CYC  = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_rise,
    input  logic i_data_bit,
    input  logic i_d_q_bit,
    output logic o_setup_hit,
    output logic o_hold_hit
);

    localparam int AGE_W = (SETUP_CYC < 1) ? 1 : $clog2(SETUP_CYC + 1);
    localparam int WIN_W = (HOLD_CYC < 1) ? 1 : $clog2(HOLD_CYC + 1);
    localparam logic [AGE_W-1:0] AGE_SAT  = AGE_W'(SETUP_CYC);
    localparam logic [WIN_W-1:0] WIN_INIT = WIN_W'(HOLD_CYC);

    logic [AGE_W-1:0] r_age;
    logic [AGE_W-1:0] w_age_nxt;
    logic [WIN_W-1:0] r_win;
    logic [WIN_W-1:0] w_win_nxt;
    logic             w_chg;

    // Age/window next state; a hit closes the window so later changes stay quiet.
    always_comb begin
        w_chg = i_data_bit ^ i_d_q_bit;
        if (w_chg) begin
            w_age_nxt = '0;
        end else if (r_age >= AGE_SAT) begin
            w_age_nxt = AGE_SAT;
        end else begin
            w_age_nxt = r_age + AGE_W'(1);
        end
        o_setup_hit = i_en & i_rise & (w_age_nxt < AGE_SAT);
        o_hold_hit  = i_en & w_chg & (r_win != '0);
        if (!i_en) begin
            w_win_nxt = '0;
        end else if (i_rise) begin
            w_win_nxt = WIN_INIT;
        end else if (o_hold_hit || (r_win == '0)) begin
            w_win_nxt = '0;
        end else begin
            w_win_nxt = r_win - WIN_W'(1);
        end
    end

    // Channel state registers; reset treats the bit as long stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_age <= AGE_SAT;
            r_win <= '0;
        end else begin
            r_age <= w_age_nxt;
            r_win <= w_win_nxt;
        end
    end

endmodule

// File: rtl/timing_check_monitor.sv
// Cycle-based setup/hold/width monitor over a bank of data channels, with
// notifier, saturating violation counter and last-violation kind.
module timing_check_monitor
    import timing_chk_pkg::*;
#(
    parameter int CHANNELS  = 8,
    parameter int SETUP_CYC = 3,
    parameter int HOLD_CYC  = 2,
    parameter int WIDTH_MIN = 4,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                ref_in,
    input  logic [CHANNELS-1:0] data,
    output logic [CHANNELS-1:0] setup_viol,
    output logic [CHANNELS-1:0] hold_viol,
    output logic                width_viol,
    output logic                notifier,
    output logic [CNT_W-1:0]    viol_count,
    output logic [1:0]          last_kind
);

    localparam int H_W = (WIDTH_MIN < 1) ? 1 : $clog2(WIDTH_MIN + 1);
    localparam logic [H_W-1:0] H_SAT = H_W'(WIDTH_MIN);

    logic                r_ref_q;
    logic [CHANNELS-1:0] r_d_q;
    logic [H_W-1:0]      r_h;
    logic [H_W-1:0]      w_h_nxt;
    logic [CHANNELS-1:0] r_setup;
    logic [CHANNELS-1:0] r_hold;
    logic                r_width;
    logic                r_notifier;
    logic [CNT_W-1:0]    r_count;
    viol_kind_t          r_last_kind;

    logic                w_rise;
    logic                w_fall;
    logic [CHANNELS-1:0] w_setup_hit;
    logic [CHANNELS-1:0] w_hold_hit;
    logic                w_width_hit;
    logic                w_any;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        tc_channel #(
            .SETUP_CYC (SETUP_CYC),
            .HOLD_CYC  (HOLD_CYC)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .i_en        (en),
            .i_rise      (w_rise),
            .i_data_bit  (data[g]),
            .i_d_q_bit   (r_d_q[g]),
            .o_setup_hit (w_setup_hit[g]),
            .o_hold_hit  (w_hold_hit[g])
        );
    end

    // Edge detect and high-phase length; the rising-edge cycle counts as the first high cycle.
    always_comb begin
        w_rise = ref_in & ~r_ref_q;
        w_fall = ~ref_in & r_ref_q;
        if (w_rise) begin
            w_h_nxt = (H_SAT != '0) ? H_W'(1) : '0;
        end else if (ref_in && (r_h < H_SAT)) begin
            w_h_nxt = r_h + H_W'(1);
        end else begin
            w_h_nxt = r_h;
        end
        w_width_hit = en & w_fall & (r_h < H_SAT);
        w_any       = (|w_setup_hit) | (|w_hold_hit) | w_width_hit;
    end

    // Registered flags, notifier, saturating counter and last kind.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref_q     <= 1'b0;
            r_d_q       <= '0;
            r_h         <= '0;
            r_setup     <= '0;
            r_hold      <= '0;
            r_width     <= 1'b0;
            r_notifier  <= 1'b0;
            r_count     <= '0;
            r_last_kind <= VK_NONE;
        end else begin
            r_ref_q <= ref_in;
            r_d_q   <= data;
            r_h     <= w_h_nxt;
            r_setup <= w_setup_hit;
            r_hold  <= w_hold_hit;
            r_width <= w_width_hit;
            if (w_any) begin
                r_notifier  <= ~r_notifier;
                r_count     <= (r_count == '1) ? r_count : r_count + CNT_W'(1);
                r_last_kind <= prio_kind(|w_setup_hit, |w_hold_hit, w_width_hit);
            end else begin
                r_notifier  <= r_notifier;
                r_count     <= r_count;
                r_last_kind <= r_last_kind;
            end
        end
    end

    assign setup_viol = r_setup;
    assign hold_viol  = r_hold;
    assign width_viol = r_width;
    assign notifier   = r_notifier;
    assign viol_count = r_count;
    assign last_kind  = r_last_kind;

endmodule
